// File: rtl/sysbus_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sysbus_mem_responder : Sysbus memory-side responder, line writes and tagged line reads
// Revision 1.0
// ============================================================================
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int BEATS          = 8,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] i_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  i_bus_reqtag,
  output logic                      o_bus_reqack,
  output logic                      o_bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] o_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  o_bus_resptag,
  input  logic                      i_bus_respack
);

  localparam int c_ADDR_W    = $clog2(MEM_WORDS);
  localparam int c_BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int c_WAIT_W    = $clog2(READ_LATENCY + 1);
  localparam int c_WAIT_LAST = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
  localparam logic [c_ADDR_W-1:0] c_LINE_MASK = ~c_ADDR_W'(BEATS - 1);
  localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_DATA = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RD_RESP = 2'd3
  } state_t;

  state_t                    r_state;
  logic [c_ADDR_W-1:0]       r_base;
  logic [c_BEAT_W-1:0]       r_beat;
  logic [c_WAIT_W-1:0]       r_wait;
  logic                      r_respcyc;
  logic [BUS_DATA_WIDTH-1:0] r_resp;
  logic [BUS_TAG_WIDTH-1:0]  r_resptag;
  logic [BUS_DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  logic                      w_accept;
  logic                      w_resp_take;
  logic                      w_wr_en;
  logic [c_ADDR_W-1:0]       w_wr_addr;
  logic [c_ADDR_W-1:0]       w_rd_addr;
  logic [BUS_DATA_WIDTH-1:0] w_rd_data;
  logic [c_ADDR_W-1:0]       w_hdr_base;
  logic                      w_unused_bits;

  // Byte offset within a word and address bits beyond the store are don't-care.
  assign w_hdr_base    = i_bus_req[c_ADDR_W+2:3] & c_LINE_MASK;
  assign w_unused_bits = &{1'b0, i_bus_req[BUS_DATA_WIDTH-1:c_ADDR_W+3], i_bus_req[2:0]};

  assign o_bus_reqack  = i_bus_reqcyc & ((r_state == S_IDLE) | (r_state == S_WR_DATA));
  assign w_accept      = i_bus_reqcyc & o_bus_reqack;
  assign w_resp_take   = r_respcyc & i_bus_respack;

  assign w_wr_en       = w_accept & (r_state == S_WR_DATA);
  assign w_wr_addr     = r_base + c_ADDR_W'(r_beat);

  // Word to load into the response register at the next edge.
  always_comb begin
    w_rd_addr = r_base;
    case (r_state)
      S_IDLE:    w_rd_addr = w_hdr_base;
      S_RD_RESP: w_rd_addr = r_base + c_ADDR_W'(r_beat) + 1'b1;
      default:   w_rd_addr = r_base;
    endcase
  end

  assign w_rd_data = r_mem[w_rd_addr];

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= i_bus_req;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_beat    <= '0;
      r_wait    <= '0;
      r_respcyc <= 1'b0;
      r_resp    <= '0;
      r_resptag <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_base    <= w_hdr_base;
            r_resptag <= i_bus_reqtag;
            r_beat    <= '0;
            r_wait    <= '0;
            if (i_bus_reqtag[BUS_TAG_WIDTH-1]) begin
              r_state <= S_WR_DATA;
            end else if (READ_LATENCY == 1) begin
              r_state   <= S_RD_RESP;
              r_respcyc <= 1'b1;
              r_resp    <= w_rd_data;
            end else begin
              r_state <= S_RD_WAIT;
            end
          end
        end
        S_WR_DATA: begin
          if (w_accept) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == c_BEAT_LAST) begin
              r_state <= S_IDLE;
            end
          end
        end
        S_RD_WAIT: begin
          if (r_wait == c_WAIT_W'(c_WAIT_LAST)) begin
            r_state   <= S_RD_RESP;
            r_respcyc <= 1'b1;
            r_resp    <= w_rd_data;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_RD_RESP: begin
          if (w_resp_take) begin
            if (r_beat == c_BEAT_LAST) begin
              r_respcyc <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_beat <= r_beat + 1'b1;
              r_resp <= w_rd_data;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_bus_respcyc = r_respcyc;
  assign o_bus_resp    = r_resp;
  assign o_bus_resptag = r_resptag;

endmodule
`default_nettype wire
